pc_stack: RTL

- Next-generation picoMIPS program counter with parametrised address width.
- Supports increment, relative branch, absolute branch, subroutine call and return.
- Call and return use an internal return-address stack (RAS) with a stall/enable input.
- Sits between the instruction decoder (control strobes, branch field) and program memory (PCout drives the instruction address).

---
 rtl/pc_pkg.sv | 40 ++++
 rtl/ret_stack.sv | 77 +++++++
 rtl/pc_stack.sv | 104 ++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared types and helpers for the picoMIPS program counter / return-address stack.
// The optional sticky error flag in pc_stack is enabled by defining PC_ERR_EN.
package pc_pkg;

   localparam int PSIZE_DEF = 8;
   localparam int DEPTH_DEF = 4;

   typedef enum logic [2:0] {
      OP_HOLD,
      OP_INCR,
      OP_REL,
      OP_ABS,
      OP_CALL,
      OP_RET
   } pc_op_t;

   // Strobe priority: return > call > absolute > relative > increment.
   function automatic pc_op_t resolve_op(
      input logic ret,
      input logic call,
      input logic abs_br,
      input logic rel_br,
      input logic incr
   );
      pc_op_t op;
      op = OP_HOLD;
      if (ret)
         op = OP_RET;
      else if (call)
         op = OP_CALL;
      else if (abs_br)
         op = OP_ABS;
      else if (rel_br)
         op = OP_REL;
      else if (incr)
         op = OP_INCR;
      return op;
   endfunction

endpackage

// File: rtl/ret_stack.sv
// Circular return-address stack: modulo-Depth top pointer plus a 0..Depth
// occupancy counter; full/empty come from the counter only.
module ret_stack import pc_pkg::*; #(
   parameter int Psize = PSIZE_DEF,
   parameter int Depth = DEPTH_DEF
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic             push,
   input  logic             pop,
   input  logic [Psize-1:0] din,
   output logic [Psize-1:0] top,
   output logic             full,
   output logic             empty,
   output logic             ovf,
   output logic             unf
);

   localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int CW = $clog2(Depth + 1);
   localparam logic [CW-1:0] COUNT_MAX = CW'(Depth);

   logic [Psize-1:0] mem [Depth];
   logic [PW-1:0]    tos_reg;
   logic [PW-1:0]    tos_next;
   logic [PW-1:0]    wr_ptr;
   logic [CW-1:0]    count_reg;
   logic [CW-1:0]    count_next;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_reg == COUNT_MAX);
   assign empty   = (count_reg == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & ~pop;
   assign wr_ptr  = tos_reg + 1'b1;
   assign top     = mem[tos_reg];

   // When full, wr_ptr lands on the oldest entry, so a push overwrites it.
   assign ovf = do_push & full;
   assign unf = pop & empty;

   always_comb begin
      tos_next   = tos_reg;
      count_next = count_reg;
      if (do_pop) begin
         tos_next   = tos_reg - 1'b1;
         count_next = count_reg - 1'b1;
      end else if (do_push) begin
         tos_next = wr_ptr;
         if (!full)
            count_next = count_reg + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         tos_reg   <= '0;
         count_reg <= '0;
      end else begin
         tos_reg   <= tos_next;
         count_reg <= count_next;
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         for (int i = 0; i < Depth; i++)
            mem[i] <= '0;
      end else if (do_push) begin
         for (int i = 0; i < Depth; i++)
            if (wr_ptr == PW'(i))
               mem[i] <= din;
      end
   end

endmodule

// File: rtl/pc_stack.sv
// picoMIPS program counter with shared adder, strobe priority mux and RAS.
// Define PC_ERR_EN to build the sticky err flag (cleared by errclr).
module pc_stack import pc_pkg::*; #(
   parameter int Psize = PSIZE_DEF,
   parameter int Depth = DEPTH_DEF
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic             en,
   input  logic             PCincr,
   input  logic             PCrelbranch,
   input  logic             PCabsbranch,
   input  logic             PCcall,
   input  logic             PCret,
   input  logic [Psize-1:0] Branchaddr,
   input  logic             errclr,
   output logic [Psize-1:0] PCout,
   output logic             sp_full,
   output logic             sp_empty,
   output logic             err
);

   pc_op_t           op;
   logic [Psize-1:0] pc_reg;
   logic [Psize-1:0] pc_next;
   logic [Psize-1:0] addend;
   logic [Psize-1:0] sum;
   logic [Psize-1:0] ras_top;
   logic             push;
   logic             pop;
   logic             ovf;
   logic             unf;
   logic             ret_empty;

   assign op        = resolve_op(PCret, PCcall, PCabsbranch, PCrelbranch, PCincr);
   assign ret_empty = (op == OP_RET) && sp_empty;

   // Single adder: only a relative branch adds the offset, everything else adds 1.
   assign addend = (op == OP_REL) ? Branchaddr : Psize'(1);
   assign sum    = pc_reg + addend;

   always_comb begin
      pc_next = pc_reg;
      case (op)
         OP_INCR: pc_next = sum;
         OP_REL:  pc_next = sum;
         OP_ABS:  pc_next = Branchaddr;
         OP_CALL: pc_next = Branchaddr;
         OP_RET:  pc_next = ret_empty ? sum : ras_top;
         default: pc_next = pc_reg;
      endcase
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset)
         pc_reg <= '0;
      else if (en)
         pc_reg <= pc_next;
   end

   assign push  = en && (op == OP_CALL);
   assign pop   = en && (op == OP_RET);
   assign PCout = pc_reg;

   ret_stack #(
      .Psize (Psize),
      .Depth (Depth)
   ) u_ret_stack (
      .clk    (clk),
      .nreset (nreset),
      .push   (push),
      .pop    (pop),
      .din    (sum),
      .top    (ras_top),
      .full   (sp_full),
      .empty  (sp_empty),
      .ovf    (ovf),
      .unf    (unf)
   );

`ifdef PC_ERR_EN
   logic err_reg;

   // A new error wins over a clear in the same cycle.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset)
         err_reg <= 1'b0;
      else if (en) begin
         if (ovf || unf)
            err_reg <= 1'b1;
         else if (errclr)
            err_reg <= 1'b0;
      end
   end

   assign err = err_reg;
`else
   logic unused_err_inputs;

   assign err               = 1'b0;
   assign unused_err_inputs = errclr ^ ovf ^ unf;
`endif

endmodule
